// File: rtl/spi_egress_pkg.sv
// Shared types and helpers for the SPI egress frame arbiter.
// Optional source-0 priority mode is selected with SPI_EGRESS_ARB_PRIO_EN.
package spi_egress_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HEADER = 2'd1;
    localparam logic [1:0] ST_DATA   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        HEADER = ST_HEADER,
        DATA   = ST_DATA
    } arb_state_e;

    localparam logic [3:0] HDR_MARK_DEF  = 4'hA;
    localparam logic [7:0] IDLE_BYTE_DEF = 8'hBC;

    function automatic logic [7:0] hdr_byte(
        input logic [3:0] mark,
        input logic [3:0] src
    );
        return {mark, src};
    endfunction

endpackage

// File: rtl/spi_egress_frame_arbiter_pick.sv
// Round-robin first-hit search over a request vector.
// Returns the requester closest to ptr, counting upwards modulo N.
module rr_arbiter_pick
    import spi_egress_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [3:0]   ptr,
    output logic         hit,
    output logic [3:0]   idx
);

    int best_d;
    int d;

    always_comb begin
        hit    = 1'b0;
        idx    = 4'd0;
        best_d = N;
        d      = 0;
        for (int j = 0; j < N; j++) begin
            // distance from ptr to j going forward around the ring
            d = (j + N - int'(ptr)) % N;
            if (req[j] && d < best_d) begin
                best_d = d;
                hit    = 1'b1;
                idx    = 4'(j);
            end
        end
    end

endmodule

// File: rtl/spi_egress_frame_arbiter.sv
// Frames N_SRC byte streams onto one SPI egress stream with a source header.
// Define SPI_EGRESS_ARB_PRIO_EN to give source 0 strict priority.
module spi_egress_frame_arbiter
    import spi_egress_pkg::*;
#(
    parameter int         N_SRC     = 2,
    parameter int         MTU       = 16,
    parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEF,
    parameter logic [3:0] HDR_MARK  = HDR_MARK_DEF
) (
    input  logic               clk,
    input  logic               resn,
    input  logic [8*N_SRC-1:0] s_axis_tdata,
    input  logic [N_SRC-1:0]   s_axis_tvalid,
    input  logic [N_SRC-1:0]   s_axis_tlast,
    output logic [N_SRC-1:0]   s_axis_tready,
    output logic [7:0]         m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic [7:0]         m_axis_tuser,
    output logic               m_axis_tlast,
    output logic [3:0]         grant_id,
    output logic               busy
);

    logic [1:0]       state;
    logic [3:0]       rr_ptr;
    logic [7:0]       byte_cnt;

    logic [7:0]       sel_data;
    logic             sel_valid;
    logic             sel_last;
    logic             frame_end;

    logic [N_SRC-1:0] pick_req;
    logic             pick_hit;
    logic [3:0]       pick_idx;
    logic             win_hit;
    logic [3:0]       win_idx;
    logic [3:0]       ptr_nxt;

    assign m_axis_tuser = IDLE_BYTE;
    assign busy         = (state != ST_IDLE);

    always_comb begin
        sel_data  = 8'h00;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_id == 4'(i)) begin
                sel_data  = s_axis_tdata[8*i +: 8];
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
            end
        end
    end

    assign frame_end = sel_last || (byte_cnt == 8'(MTU - 1));

`ifdef SPI_EGRESS_ARB_PRIO_EN
    // source 0 bypasses the ring; the ring only serves 1..N_SRC-1
    assign pick_req = s_axis_tvalid & ~N_SRC'(1);
`else
    assign pick_req = s_axis_tvalid;
`endif

    rr_arbiter_pick #(
        .N (N_SRC)
    ) u_pick (
        .req (pick_req),
        .ptr (rr_ptr),
        .hit (pick_hit),
        .idx (pick_idx)
    );

    always_comb begin
        win_hit = pick_hit;
        win_idx = pick_idx;
`ifdef SPI_EGRESS_ARB_PRIO_EN
        if (s_axis_tvalid[0]) begin
            win_hit = 1'b1;
            win_idx = 4'd0;
        end
`endif
    end

    always_comb begin
        if (grant_id == 4'(N_SRC - 1)) begin
            ptr_nxt = 4'd0;
        end else begin
            ptr_nxt = grant_id + 4'd1;
        end
`ifdef SPI_EGRESS_ARB_PRIO_EN
        if (ptr_nxt == 4'd0 && N_SRC > 1) begin
            ptr_nxt = 4'd1;
        end
`endif
    end

    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = 8'h00;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        unique case (state)
            ST_HEADER: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_byte(HDR_MARK, grant_id);
            end
            ST_DATA: begin
                m_axis_tvalid = sel_valid;
                m_axis_tdata  = sel_data;
                m_axis_tlast  = sel_valid && frame_end;
                for (int i = 0; i < N_SRC; i++) begin
                    if (grant_id == 4'(i)) begin
                        s_axis_tready[i] = m_axis_tready;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            state    <= ST_IDLE;
            rr_ptr   <= 4'd0;
            byte_cnt <= 8'd0;
            grant_id <= 4'd0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (win_hit) begin
                        grant_id <= win_idx;
                        state    <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (m_axis_tready) begin
                        state    <= ST_DATA;
                        byte_cnt <= 8'd0;
                    end
                end
                ST_DATA: begin
                    if (sel_valid && m_axis_tready) begin
                        if (frame_end) begin
                            state    <= ST_IDLE;
                            rr_ptr   <= ptr_nxt;
                            byte_cnt <= 8'd0;
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_egress_frame_arbiter.sv
// Scoreboard bench for spi_egress_frame_arbiter (3 sources, MTU 4).
// Expected stream is queued by the stimulus; a negedge monitor checks it.
module tb_spi_egress_frame_arbiter;

    localparam int N   = 3;
    localparam int MTU = 4;

    logic           clk = 1'b0;
    logic           resn = 1'b0;
    logic [8*N-1:0] s_tdata = '0;
    logic [N-1:0]   s_tvalid = '0;
    logic [N-1:0]   s_tlast = '0;
    logic [N-1:0]   s_tready;
    logic [7:0]     m_tdata;
    logic           m_tvalid;
    logic           m_tready = 1'b1;
    logic [7:0]     m_tuser;
    logic           m_tlast;
    logic [3:0]     grant_id;
    logic           busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] sq [N][$];
    logic [8:0] exp_q [$];
    logic [N-1:0] acc = '0;
    logic [N-1:0] gate = '0;
    bit bp_mode = 1'b0;
    bit stalled = 1'b0;
    logic [7:0] held = 8'h00;

    always #5 clk = ~clk;

    spi_egress_frame_arbiter #(
        .N_SRC     (N),
        .MTU       (MTU),
        .IDLE_BYTE (8'hBC),
        .HDR_MARK  (4'hA)
    ) dut (
        .clk           (clk),
        .resn          (resn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tuser  (m_tuser),
        .m_axis_tlast  (m_tlast),
        .grant_id      (grant_id),
        .busy          (busy)
    );

    // source models: hold the queue head until it is accepted
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && sq[i].size() > 0) begin
                void'(sq[i].pop_front());
            end
            if (sq[i].size() > 0 && !gate[i]) begin
                s_tvalid[i]       = 1'b1;
                s_tdata[8*i +: 8] = sq[i][0][7:0];
                s_tlast[i]        = sq[i][0][8];
            end else begin
                s_tvalid[i]       = 1'b0;
                s_tdata[8*i +: 8] = 8'h00;
                s_tlast[i]        = 1'b0;
            end
        end
        m_tready = bp_mode ? ~m_tready : 1'b1;
    end

    always @(negedge clk) begin
        acc = s_tvalid & s_tready;
        if (!resn) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                n_cmp++;
                if (!m_tvalid || m_tdata !== held) begin
                    n_err++;
                    $display("FAIL stable: got v=%0b d=%02h required v=1 d=%02h",
                             m_tvalid, m_tdata, held);
                end
            end
            if (m_tvalid && m_tready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_byte: got d=%02h l=%0b required none",
                             m_tdata, m_tlast);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    if ({m_tlast, m_tdata} !== e) begin
                        n_err++;
                        $display("FAIL stream: got l=%0b d=%02h required l=%0b d=%02h",
                                 m_tlast, m_tdata, e[8], e[7:0]);
                    end
                end
                stalled = 1'b0;
            end else if (m_tvalid) begin
                stalled = 1'b1;
                held    = m_tdata;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic put(input int src, input logic [7:0] d, input logic l);
        sq[src].push_back({l, d});
    endtask

    task automatic exb(input logic [7:0] d, input logic l);
        exp_q.push_back({l, d});
    endtask

    task automatic exh(input logic [3:0] src);
        exp_q.push_back({1'b0, 4'hA, src});
    endtask

    function automatic bit src_pending();
        bit p;
        p = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sq[i].size() > 0) p = 1'b1;
        end
        return p;
    endfunction

    task automatic drain(input string name, input int max);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy || src_pending()) && t < max) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t >= max) begin
            n_err++;
            $display("FAIL %s_timeout: got %0d left required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tuser", 32'(m_tuser), 32'hBC);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tready", 32'(s_tready), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_tlast", 32'(m_tlast), 32'd0);
        resn = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_tvalid", 32'(m_tvalid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_tready", 32'(s_tready), 32'd0);

        // single packet from source 1
        put(1, 8'h11, 1'b0); put(1, 8'h22, 1'b0); put(1, 8'h33, 1'b1);
        exh(4'd1); exb(8'h11, 1'b0); exb(8'h22, 1'b0); exb(8'h33, 1'b1);
        drain("single", 60);
        chk("single_grant", 32'(grant_id), 32'd1);
        chk("single_busy", 32'(busy), 32'd0);

        // two competing sources, two 2-byte packets each
        put(0, 8'h01, 1'b0); put(0, 8'h02, 1'b1);
        put(0, 8'h03, 1'b0); put(0, 8'h04, 1'b1);
        put(1, 8'h81, 1'b0); put(1, 8'h82, 1'b1);
        put(1, 8'h83, 1'b0); put(1, 8'h84, 1'b1);
`ifdef SPI_EGRESS_ARB_PRIO_EN
        exh(4'd0); exb(8'h01, 1'b0); exb(8'h02, 1'b1);
        exh(4'd0); exb(8'h03, 1'b0); exb(8'h04, 1'b1);
        exh(4'd1); exb(8'h81, 1'b0); exb(8'h82, 1'b1);
        exh(4'd1); exb(8'h83, 1'b0); exb(8'h84, 1'b1);
`else
        exh(4'd0); exb(8'h01, 1'b0); exb(8'h02, 1'b1);
        exh(4'd1); exb(8'h81, 1'b0); exb(8'h82, 1'b1);
        exh(4'd0); exb(8'h03, 1'b0); exb(8'h04, 1'b1);
        exh(4'd1); exb(8'h83, 1'b0); exb(8'h84, 1'b1);
`endif
        drain("rr", 120);

        // 6-byte packet cut at MTU 4, source 0 alone
        for (int k = 0; k < 6; k++) put(0, 8'(8'h10 + k), 1'(k == 5));
        exh(4'd0);
        exb(8'h10, 1'b0); exb(8'h11, 1'b0); exb(8'h12, 1'b0); exb(8'h13, 1'b1);
        exh(4'd0); exb(8'h14, 1'b0); exb(8'h15, 1'b1);
        drain("mtu_alone", 80);

        // tlast coincides with the MTU limit: one frame only
        for (int k = 0; k < 4; k++) put(0, 8'(8'h20 + k), 1'(k == 3));
        exh(4'd0);
        exb(8'h20, 1'b0); exb(8'h21, 1'b0); exb(8'h22, 1'b0); exb(8'h23, 1'b1);
        drain("mtu_last", 60);

        // MTU cut while source 1 becomes valid mid-frame
        for (int k = 0; k < 6; k++) put(0, 8'(8'h30 + k), 1'(k == 5));
        exh(4'd0);
        exb(8'h30, 1'b0); exb(8'h31, 1'b0); exb(8'h32, 1'b0); exb(8'h33, 1'b1);
`ifdef SPI_EGRESS_ARB_PRIO_EN
        exh(4'd0); exb(8'h34, 1'b0); exb(8'h35, 1'b1);
        exh(4'd1); exb(8'h55, 1'b1);
`else
        exh(4'd1); exb(8'h55, 1'b1);
        exh(4'd0); exb(8'h34, 1'b0); exb(8'h35, 1'b1);
`endif
        begin
            int t;
            t = 0;
            while (!busy && t < 20) begin
                @(negedge clk);
                t++;
            end
            chk("mtu_busy_seen", 32'(busy), 32'd1);
        end
        put(1, 8'h55, 1'b1);
        drain("mtu_cut", 80);

        // sink backpressure toggling every cycle
        bp_mode = 1'b1;
        put(2, 8'h40, 1'b0); put(2, 8'h41, 1'b0); put(2, 8'h42, 1'b1);
        exh(4'd2); exb(8'h40, 1'b0); exb(8'h41, 1'b0); exb(8'h42, 1'b1);
        drain("bp", 100);
        bp_mode = 1'b0;
        repeat (2) @(negedge clk);

        // granted source stalls for 5 cycles mid-frame
        put(1, 8'h50, 1'b0);
        exh(4'd1); exb(8'h50, 1'b0); exb(8'h51, 1'b0); exb(8'h52, 1'b1);
        begin
            int t;
            t = 0;
            while (sq[1].size() != 0 && t < 40) begin
                @(negedge clk);
                t++;
            end
            chk("stall_first_byte", 32'(sq[1].size()), 32'd0);
        end
        gate[1] = 1'b1;
        put(1, 8'h51, 1'b0); put(1, 8'h52, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_tvalid", 32'(m_tvalid), 32'd0);
            chk("stall_grant", 32'(grant_id), 32'd1);
            chk("stall_busy", 32'(busy), 32'd1);
        end
        gate[1] = 1'b0;
        drain("stall", 60);

        // reset after two payload bytes
        put(0, 8'h60, 1'b0); put(0, 8'h61, 1'b0); put(0, 8'h62, 1'b1);
        exh(4'd0); exb(8'h60, 1'b0); exb(8'h61, 1'b0);
        begin
            int t;
            t = 0;
            while (sq[0].size() != 1 && t < 40) begin
                @(posedge clk);
                #2;
                t++;
            end
            chk("rstmid_reached", 32'(sq[0].size()), 32'd1);
        end
        resn = 1'b0;
        #1;
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_tvalid", 32'(m_tvalid), 32'd0);
        chk("rstmid_tlast", 32'(m_tlast), 32'd0);
        chk("rstmid_grant", 32'(grant_id), 32'd0);
        chk("rstmid_tready", 32'(s_tready), 32'd0);
        chk("rstmid_emitted", 32'(exp_q.size()), 32'd0);
        sq[0].delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        resn = 1'b1;
        @(negedge clk);

        // sources 0 and 2 contend right after reset
        put(0, 8'h70, 1'b1); put(0, 8'h71, 1'b1);
        put(2, 8'h90, 1'b1); put(2, 8'h91, 1'b1);
`ifdef SPI_EGRESS_ARB_PRIO_EN
        exh(4'd0); exb(8'h70, 1'b1);
        exh(4'd0); exb(8'h71, 1'b1);
        exh(4'd2); exb(8'h90, 1'b1);
        exh(4'd2); exb(8'h91, 1'b1);
`else
        exh(4'd0); exb(8'h70, 1'b1);
        exh(4'd2); exb(8'h90, 1'b1);
        exh(4'd0); exb(8'h71, 1'b1);
        exh(4'd2); exb(8'h91, 1'b1);
`endif
        drain("prio", 80);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_grant", 32'(grant_id), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
